wb_sram_bridge: RTL and testbench

- Wishbone classic slave that sits directly upstream of the two OpenRAM 1rw1r macros:
  - SRAM A: 32x256.
  - SRAM B: 32x512.
- Decodes user-area bus cycles into registered csb/web/wmask/addr/din for both ports of each macro.
- Waits out the macro read latency, returns read data and generates wbs_ack_o.
- Also exposes an ID register and a completed-transaction counter for bring-up.

---
 rtl/wb_sram_bridge_pkg.sv | 37 +++
 rtl/wb_sram_bridge_if.sv | 24 ++
 rtl/wb_sram_bridge.sv | 176 +++++++++++++++++
 tb/tb_wb_sram_bridge.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_sram_bridge_pkg.sv
// Shared constants and types for the Wishbone-to-OpenRAM bridge.
package wb_sram_pkg;

   localparam int DATA_W   = 32;
   localparam int MASK_W   = 4;
   localparam int ADDR_A_W = 8;
   localparam int ADDR_B_W = 9;

   // Region codes taken from wbs_adr_i[15:12]
   localparam logic [3:0] RGN_A0   = 4'h0;
   localparam logic [3:0] RGN_A1   = 4'h1;
   localparam logic [3:0] RGN_B0   = 4'h2;
   localparam logic [3:0] RGN_B1   = 4'h3;
   localparam logic [3:0] RGN_STAT = 4'hF;

   // Word offsets inside the status region (wbs_adr_i[11:2])
   localparam logic [9:0] STAT_ID_WORD  = 10'd0;
   localparam logic [9:0] STAT_CNT_WORD = 10'd1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_ACK
   } state_e;

   // Regions backed by a macro port
   function automatic logic is_sram(input logic [3:0] rgn);
      return rgn <= RGN_B1;
   endfunction

   // Port1 of each macro is read-only
   function automatic logic is_ro(input logic [3:0] rgn);
      return (rgn == RGN_A1) || (rgn == RGN_B1);
   endfunction

endpackage

// File: rtl/wb_sram_bridge_if.sv
// Wishbone classic slave-side bus bundle.
interface wb_sram_bridge_if;
   import wb_sram_pkg::*;

   logic              wbs_cyc_i;
   logic              wbs_stb_i;
   logic              wbs_we_i;
   logic [MASK_W-1:0] wbs_sel_i;
   logic [DATA_W-1:0] wbs_dat_i;
   logic [31:0]       wbs_adr_i;
   logic              wbs_ack_o;
   logic [DATA_W-1:0] wbs_dat_o;

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
      output wbs_ack_o, wbs_dat_o
   );

   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
      input  wbs_ack_o, wbs_dat_o
   );

endinterface

// File: rtl/wb_sram_bridge.sv
// Wishbone classic slave driving two OpenRAM 1rw1r macros (A: 32x256,
// B: 32x512), plus an ID word and a completed-transaction counter.
module wb_sram_bridge
   import wb_sram_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int unsigned READ_WAIT = 1,
   parameter logic [31:0] ID_VALUE  = 32'h5352_414D
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   wb_sram_bridge_if.slave     wb,

   output logic                csbA0,
   output logic                csbA1,
   output logic                webA,
   output logic [MASK_W-1:0]   wmaskA,
   output logic [ADDR_A_W-1:0] addrA0,
   output logic [ADDR_A_W-1:0] addrA1,
   output logic [DATA_W-1:0]   dinA0,
   input  logic [DATA_W-1:0]   sram1_dout0,
   input  logic [DATA_W-1:0]   sram1_dout1,

   output logic                csbB0,
   output logic                csbB1,
   output logic                webB,
   output logic [MASK_W-1:0]   wmaskB,
   output logic [ADDR_B_W-1:0] addrB0,
   output logic [ADDR_B_W-1:0] addrB1,
   output logic [DATA_W-1:0]   dinB0,
   input  logic [DATA_W-1:0]   sram12_dout0,
   input  logic [DATA_W-1:0]   sram12_dout1
);

   localparam logic [2:0] WAIT_INIT = 3'(READ_WAIT - 1);

   state_e      state;
   logic [2:0]  wait_cnt;
   logic [31:0] txn_cnt;
   logic [3:0]  cur_rgn;
   logic        cur_we;

   logic              req;
   logic [3:0]        rgn;
   logic [9:0]        stat_word;
   logic [DATA_W-1:0] stat_val;
   logic [DATA_W-1:0] rd_mux;

   // byte offset bits are don't-care for a word-wide bus
   logic unused_adr;
   assign unused_adr = ^wb.wbs_adr_i[1:0];

   // Request decode, status read value and macro read-data select
   always_comb begin
      req       = wb.wbs_cyc_i & wb.wbs_stb_i &
                  (wb.wbs_adr_i[31:16] == BASE_ADDR[31:16]);
      rgn       = wb.wbs_adr_i[15:12];
      stat_word = wb.wbs_adr_i[11:2];
      stat_val  = '0;
      if (stat_word == STAT_ID_WORD)       stat_val = ID_VALUE;
      else if (stat_word == STAT_CNT_WORD) stat_val = txn_cnt;
      case (cur_rgn)
         RGN_A0:  rd_mux = sram1_dout0;
         RGN_A1:  rd_mux = sram1_dout1;
         RGN_B0:  rd_mux = sram12_dout0;
         RGN_B1:  rd_mux = sram12_dout1;
         default: rd_mux = '0;
      endcase
   end

   // Bus FSM: one macro access per request, all outputs registered
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state        <= ST_IDLE;
         wait_cnt     <= '0;
         txn_cnt      <= '0;
         cur_rgn      <= '0;
         cur_we       <= 1'b0;
         wb.wbs_ack_o <= 1'b0;
         wb.wbs_dat_o <= '0;
         csbA0        <= 1'b1;
         csbA1        <= 1'b1;
         webA         <= 1'b1;
         wmaskA       <= '0;
         addrA0       <= '0;
         addrA1       <= '0;
         dinA0        <= '0;
         csbB0        <= 1'b1;
         csbB1        <= 1'b1;
         webB         <= 1'b1;
         wmaskB       <= '0;
         addrB0       <= '0;
         addrB1       <= '0;
         dinB0        <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               wb.wbs_ack_o <= 1'b0;
               if (req) begin
                  cur_rgn <= rgn;
                  cur_we  <= wb.wbs_we_i;
                  if (is_sram(rgn) && !(wb.wbs_we_i && is_ro(rgn))) begin
                     case (rgn)
                        RGN_A0: begin
                           csbA0  <= 1'b0;
                           addrA0 <= wb.wbs_adr_i[9:2];   // adr[10] ignored: A aliases
                           if (wb.wbs_we_i) begin
                              webA   <= 1'b0;
                              wmaskA <= wb.wbs_sel_i;
                              dinA0  <= wb.wbs_dat_i;
                           end
                        end
                        RGN_A1: begin
                           csbA1  <= 1'b0;
                           addrA1 <= wb.wbs_adr_i[9:2];
                        end
                        RGN_B0: begin
                           csbB0  <= 1'b0;
                           addrB0 <= wb.wbs_adr_i[10:2];
                           if (wb.wbs_we_i) begin
                              webB   <= 1'b0;
                              wmaskB <= wb.wbs_sel_i;
                              dinB0  <= wb.wbs_dat_i;
                           end
                        end
                        default: begin
                           csbB1  <= 1'b0;
                           addrB1 <= wb.wbs_adr_i[10:2];
                        end
                     endcase
                     state <= ST_ISSUE;
                  end else begin
                     // no macro involved: answer on the next cycle
                     wb.wbs_dat_o <= (rgn == RGN_STAT && !wb.wbs_we_i) ? stat_val : '0;
                     wb.wbs_ack_o <= 1'b1;
                     state        <= ST_ACK;
                  end
               end
            end
            ST_ISSUE: begin
               // macro samples on this edge; release the controls
               csbA0 <= 1'b1;
               csbA1 <= 1'b1;
               webA  <= 1'b1;
               csbB0 <= 1'b1;
               csbB1 <= 1'b1;
               webB  <= 1'b1;
               if (cur_we) begin
                  wb.wbs_ack_o <= 1'b1;
                  state        <= ST_ACK;
               end else begin
                  wait_cnt <= WAIT_INIT;
                  state    <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (!wb.wbs_cyc_i) begin
                  state <= ST_IDLE;             // master gave up: no ack, no count
               end else if (wait_cnt == 3'd0) begin
                  wb.wbs_dat_o <= rd_mux;
                  wb.wbs_ack_o <= 1'b1;
                  state        <= ST_ACK;
               end else begin
                  wait_cnt <= wait_cnt - 3'd1;
               end
            end
            default: begin                      // ST_ACK
               wb.wbs_ack_o <= 1'b0;
               txn_cnt      <= txn_cnt + 32'd1;
               state        <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_sram_bridge.sv
// Bench for wb_sram_bridge: behavioural macro models, a transaction-level
// reference memory/counter, directed steps then randomized traffic.
module tb_wb_sram_bridge;

   localparam logic [31:0] ID  = 32'h5352_414D;
   localparam logic [31:0] C3  = 32'h600D_D00D;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wb_sram_bridge_if bus1 ();
   wb_sram_bridge_if bus3 ();

   // DUT1 (READ_WAIT=1) macro-side signals
   logic        csbA0, csbA1, webA, csbB0, csbB1, webB;
   logic [3:0]  wmaskA, wmaskB;
   logic [7:0]  addrA0, addrA1;
   logic [8:0]  addrB0, addrB1;
   logic [31:0] dinA0, dinB0, doutA0, doutA1, doutB0, doutB1;

   // DUT3 (READ_WAIT=3) macro-side signals; its macros return constants
   logic        t3_csbA0, t3_csbA1, t3_webA, t3_csbB0, t3_csbB1, t3_webB;
   logic [3:0]  t3_wmaskA, t3_wmaskB;
   logic [7:0]  t3_addrA0, t3_addrA1;
   logic [8:0]  t3_addrB0, t3_addrB1;
   logic [31:0] t3_dinA0, t3_dinB0;
   logic [31:0] t3_zero;
   assign t3_zero = '0;

   wb_sram_bridge #(.READ_WAIT(1)) dut1 (
      .wb_clk_i(clk), .wb_rst_i(rst), .wb(bus1),
      .csbA0(csbA0), .csbA1(csbA1), .webA(webA), .wmaskA(wmaskA),
      .addrA0(addrA0), .addrA1(addrA1), .dinA0(dinA0),
      .sram1_dout0(doutA0), .sram1_dout1(doutA1),
      .csbB0(csbB0), .csbB1(csbB1), .webB(webB), .wmaskB(wmaskB),
      .addrB0(addrB0), .addrB1(addrB1), .dinB0(dinB0),
      .sram12_dout0(doutB0), .sram12_dout1(doutB1)
   );

   wb_sram_bridge #(.READ_WAIT(3)) dut3 (
      .wb_clk_i(clk), .wb_rst_i(rst), .wb(bus3),
      .csbA0(t3_csbA0), .csbA1(t3_csbA1), .webA(t3_webA), .wmaskA(t3_wmaskA),
      .addrA0(t3_addrA0), .addrA1(t3_addrA1), .dinA0(t3_dinA0),
      .sram1_dout0(C3), .sram1_dout1(t3_zero),
      .csbB0(t3_csbB0), .csbB1(t3_csbB1), .webB(t3_webB), .wmaskB(t3_wmaskB),
      .addrB0(t3_addrB0), .addrB1(t3_addrB1), .dinB0(t3_dinB0),
      .sram12_dout0(t3_zero), .sram12_dout1(t3_zero)
   );

   // Behavioural 1rw1r macros for DUT1
   logic [31:0] memA [256];
   logic [31:0] memB [512];
   always @(posedge clk) begin
      if (!csbA0) begin
         if (!webA) begin
            for (int b = 0; b < 4; b++)
               if (wmaskA[b]) memA[addrA0][8*b +: 8] <= dinA0[8*b +: 8];
         end else doutA0 <= memA[addrA0];
      end
      if (!csbA1) doutA1 <= memA[addrA1];
      if (!csbB0) begin
         if (!webB) begin
            for (int b = 0; b < 4; b++)
               if (wmaskB[b]) memB[addrB0][8*b +: 8] <= dinB0[8*b +: 8];
         end else doutB0 <= memB[addrB0];
      end
      if (!csbB1) doutB1 <= memB[addrB1];
   end

   // Reference model: word arrays and transaction count
   logic [31:0] refA [256];
   logic [31:0] refB [512];
   logic [31:0] ref_cnt;

   int n_pass = 0, n_fail = 0, n_total = 0;

   // results of the last bus transaction
   logic        r_ack;
   int          r_lat, r_csb;
   logic [31:0] r_dat;
   logic [3:0]  s_csb;
   logic [1:0]  s_web;
   logic [7:0]  s_addrA0;
   logic [8:0]  s_addrB1;
   logic [3:0]  s_wmaskA;
   logic [31:0] s_dinA0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] m;
      m = o;
      for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = d[8*b +: 8];
      return m;
   endfunction

   // One Wishbone cycle on DUT1; records latency, csb activity, first-cycle snapshot
   task automatic bus(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                      input logic [31:0] dat, input int limit);
      @(negedge clk);
      bus1.wbs_cyc_i = 1'b1; bus1.wbs_stb_i = 1'b1; bus1.wbs_we_i = we;
      bus1.wbs_adr_i = adr;  bus1.wbs_sel_i = sel;  bus1.wbs_dat_i = dat;
      r_ack = 1'b0; r_lat = 0; r_csb = 0; r_dat = '0;
      for (int i = 1; i <= limit && !r_ack; i++) begin
         @(negedge clk);
         if (i == 1) begin
            s_csb = {csbA0, csbA1, csbB0, csbB1}; s_web = {webA, webB};
            s_addrA0 = addrA0; s_addrB1 = addrB1; s_wmaskA = wmaskA; s_dinA0 = dinA0;
         end
         if ({csbA0, csbA1, csbB0, csbB1} != 4'hF) r_csb++;
         if (bus1.wbs_ack_o) begin
            r_ack = 1'b1; r_lat = i; r_dat = bus1.wbs_dat_o;
         end
      end
      bus1.wbs_cyc_i = 1'b0; bus1.wbs_stb_i = 1'b0; bus1.wbs_we_i = 1'b0;
   endtask

   // Transaction checked against the reference model (READ_WAIT=1)
   task automatic do_txn(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat, input string tag);
      logic [3:0]  rgn;
      logic        mine, sram;
      int          exp_lat;
      logic [31:0] exp_dat;
      rgn     = adr[15:12];
      mine    = (adr[31:16] == 16'h3000);
      sram    = (rgn <= 4'h3) && !(we && rgn[0]);
      exp_lat = !mine ? 0 : sram ? (we ? 2 : 3) : 1;
      exp_dat = '0;
      if (rgn == 4'h0 || rgn == 4'h1)      exp_dat = refA[adr[9:2]];
      else if (rgn == 4'h2 || rgn == 4'h3) exp_dat = refB[adr[10:2]];
      else if (rgn == 4'hF) begin
         if (adr[11:2] == 10'd0)      exp_dat = ID;
         else if (adr[11:2] == 10'd1) exp_dat = ref_cnt;
      end
      bus(we, adr, sel, dat, 12);
      chk({tag, "_lat"}, r_lat, exp_lat);
      chk({tag, "_csb"}, r_csb, (mine && sram) ? 1 : 0);
      if (!we && mine) chk({tag, "_dat"}, r_dat, exp_dat);
      if (mine) begin
         ref_cnt = ref_cnt + 32'd1;
         if (we && rgn == 4'h0) refA[adr[9:2]]  = merge(refA[adr[9:2]], dat, sel);
         if (we && rgn == 4'h2) refB[adr[10:2]] = merge(refB[adr[10:2]], dat, sel);
      end
   endtask

   // Read on DUT3
   task automatic bus3_rd(input logic [31:0] adr);
      @(negedge clk);
      bus3.wbs_cyc_i = 1'b1; bus3.wbs_stb_i = 1'b1; bus3.wbs_we_i = 1'b0;
      bus3.wbs_adr_i = adr;
      r_ack = 1'b0; r_lat = 0; r_dat = '0;
      for (int i = 1; i <= 12 && !r_ack; i++) begin
         @(negedge clk);
         if (bus3.wbs_ack_o) begin r_ack = 1'b1; r_lat = i; r_dat = bus3.wbs_dat_o; end
      end
      bus3.wbs_cyc_i = 1'b0; bus3.wbs_stb_i = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      logic [3:0]  rgn_tab [6];
      logic [3:0]  rgn;
      logic [31:0] adr;
      rgn_tab = '{4'h0, 4'h1, 4'h2, 4'h3, 4'hF, 4'h7};

      bus1.wbs_cyc_i = 0; bus1.wbs_stb_i = 0; bus1.wbs_we_i = 0;
      bus1.wbs_sel_i = 0; bus1.wbs_dat_i = 0; bus1.wbs_adr_i = 0;
      bus3.wbs_cyc_i = 0; bus3.wbs_stb_i = 0; bus3.wbs_we_i = 0;
      bus3.wbs_sel_i = 0; bus3.wbs_dat_i = 0; bus3.wbs_adr_i = 0;
      ref_cnt = '0;
      for (int i = 0; i < 256; i++) refA[i] = '0;
      for (int i = 0; i < 512; i++) refB[i] = '0;

      // reset state
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_csb_web", {csbA0, csbA1, csbB0, csbB1, webA, webB}, 32'h3F);
      chk("rst_mask", {wmaskA, wmaskB}, 32'h0);
      chk("rst_addrA", {addrA0, addrA1}, 32'h0);
      chk("rst_addrB", {addrB0, addrB1}, 32'h0);
      chk("rst_dinA", dinA0, 32'h0);
      chk("rst_dinB", dinB0, 32'h0);
      chk("rst_ack", {bus1.wbs_ack_o, bus3.wbs_ack_o}, 32'h0);
      chk("rst_dat", bus1.wbs_dat_o, 32'h0);
      rst = 1'b0;

      // region 0 write then read back
      do_txn(1'b1, 32'h3000_0014, 4'hF, 32'hCAFE_BABE, "wrA");
      chk("wrA_snap", {s_csb, s_web, s_addrA0, s_wmaskA}, {14'b0, 4'b0111, 2'b01, 8'h05, 4'hF});
      chk("wrA_din", s_dinA0, 32'hCAFE_BABE);
      do_txn(1'b0, 32'h3000_0014, 4'hF, 32'h0, "rdA");
      chk("rdA_val", r_dat, 32'hCAFE_BABE);
      do_txn(1'b0, 32'h3000_0414, 4'hF, 32'h0, "rdA_alias");
      chk("rdA_alias_val", r_dat, 32'hCAFE_BABE);

      // region 2 masked write, read via port1
      do_txn(1'b1, 32'h3000_27FC, 4'hF, 32'hFFFF_FFFF, "wrB_full");
      do_txn(1'b1, 32'h3000_27FC, 4'b0101, 32'h1122_3344, "wrB_mask");
      do_txn(1'b0, 32'h3000_37FC, 4'hF, 32'h0, "rdB1");
      chk("rdB1_snap", {s_csb, s_addrB1}, {19'b0, 4'b1110, 9'h1FF});
      chk("rdB1_val", r_dat, 32'hFF22_FF44);

      // ro write, unmapped read, status
      do_txn(1'b1, 32'h3000_1014, 4'hF, 32'hDEAD_BEEF, "wr_ro");
      do_txn(1'b0, 32'h3000_1014, 4'hF, 32'h0, "rdA1");
      chk("rdA1_val", r_dat, 32'hCAFE_BABE);
      do_txn(1'b0, 32'h3000_7000, 4'hF, 32'h0, "rd_unmap");
      do_txn(1'b1, 32'h3000_F004, 4'hF, 32'h1234_5678, "wr_stat");
      do_txn(1'b0, 32'h3000_F000, 4'hF, 32'h0, "rd_id");
      chk("rd_id_val", r_dat, ID);
      do_txn(1'b0, 32'h3001_0014, 4'hF, 32'h0, "bad_base");
      chk("bad_base_ack", r_ack, 1'b0);

      // reset while the write is in ISSUE
      @(negedge clk);
      bus1.wbs_cyc_i = 1; bus1.wbs_stb_i = 1; bus1.wbs_we_i = 1;
      bus1.wbs_adr_i = 32'h3000_0024; bus1.wbs_sel_i = 4'hF; bus1.wbs_dat_i = 32'h1234_5678;
      @(negedge clk);
      chk("iss_csb", csbA0, 1'b0);
      rst = 1'b1;
      bus1.wbs_cyc_i = 0; bus1.wbs_stb_i = 0; bus1.wbs_we_i = 0;
      @(negedge clk);
      chk("midrst_csb", {csbA0, csbA1, csbB0, csbB1}, 32'hF);
      chk("midrst_ack", bus1.wbs_ack_o, 1'b0);
      chk("midrst_dat", bus1.wbs_dat_o, 32'h0);
      rst = 1'b0;
      refA[9] = 32'h1234_5678;
      ref_cnt = '0;

      // three transactions, then the counter
      do_txn(1'b0, 32'h3000_0024, 4'hF, 32'h0, "rd_after_rst");
      chk("rd_after_rst_val", r_dat, 32'h1234_5678);
      do_txn(1'b1, 32'h3000_0028, 4'hF, 32'h0000_000A, "wr_w10");
      do_txn(1'b0, 32'h3000_7000, 4'hF, 32'h0, "rd_unmap2");
      do_txn(1'b0, 32'h3000_F004, 4'hF, 32'h0, "rd_cnt");
      chk("rd_cnt_val", r_dat, 32'd3);

      // abort during WAIT on the READ_WAIT=3 instance
      @(negedge clk);
      bus3.wbs_cyc_i = 1; bus3.wbs_stb_i = 1; bus3.wbs_we_i = 0; bus3.wbs_adr_i = 32'h3000_0014;
      @(negedge clk);
      @(negedge clk);
      bus3.wbs_cyc_i = 0; bus3.wbs_stb_i = 0;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (bus3.wbs_ack_o) seen++;
      end
      chk("abort_noack", seen, 0);
      bus3_rd(32'h3000_F004);
      chk("abort_cnt_lat", r_lat, 1);
      chk("abort_cnt", r_dat, 32'd0);
      bus3_rd(32'h3000_0014);
      chk("rw3_lat", r_lat, 5);
      chk("rw3_dat", r_dat, C3);
      bus3_rd(32'h3000_F004);
      chk("rw3_cnt", r_dat, 32'd2);

      // randomized traffic over a preset window of words
      for (int w = 0; w < 8; w++)
         do_txn(1'b1, 32'h3000_0000 | (w << 2), 4'hF, $urandom, "initA");
      for (int w = 0; w < 8; w++)
         do_txn(1'b1, 32'h3000_27E0 | (w << 2), 4'hF, $urandom, "initB");
      for (int k = 0; k < 60; k++) begin
         rgn = rgn_tab[$urandom_range(0, 5)];
         adr = 32'h3000_0000 | (32'(rgn) << 12);
         if (rgn <= 4'h1)      adr = adr | ($urandom_range(0, 1) << 10) | ($urandom_range(0, 7) << 2);
         else if (rgn <= 4'h3) adr = adr | ((9'h1F8 + $urandom_range(0, 7)) << 2);
         else if (rgn == 4'hF) adr = adr | ($urandom_range(0, 3) << 2);
         else                  adr = adr | ($urandom & 32'h0FFC);
         if ($urandom_range(0, 7) == 0) adr[31:16] = 16'h3001;
         do_txn(1'($urandom_range(0, 1)), adr, 4'($urandom), $urandom, "rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
